mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ISIZE, default 16, address and length width in bits.
REQ-002 Parameter DSIZE, default 32, data word width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src  input  ISIZE  first source word address; sampled with start.
REQ-007 dst  input  ISIZE  first destination word address; sampled with start.
REQ-008 len  input  ISIZE  number of words to copy; sampled with start.
REQ-009 abort  input  1  stop the copy after the current word completes.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a copy finishes or is aborted.
REQ-012 aborted  output  1  high during the done pulse when the copy ended by abort.
REQ-013 words_done  output  ISIZE  count of words written in the current or last copy.
REQ-014 mem_addr  output  ISIZE  word address to the memory port.
REQ-015 mem_wen  output  1  active-high write enable to the memory port.
REQ-016 mem_wdata  output  DSIZE  write data to the memory port.
REQ-017 mem_rdata  input  DSIZE  read data from the memory port.

Function
REQ-018 The memory port SHALL be treated as follows: an address presented in cycle N is registered at the end of N, and its read data is valid on mem_rdata throughout cycle N+1. A write occurs at the end of any cycle with mem_wen=1.
REQ-019 The FSM SHALL have states IDLE, RD, CAP, WR and FIN.
REQ-020 In IDLE with start=1 and len!=0, the block SHALL latch src, dst and len, clear words_done, clear its word index and enter RD.
REQ-021 In IDLE with start=1 and len=0, the block SHALL enter FIN directly and perform no memory access.
REQ-022 RD SHALL drive mem_addr=src+index and mem_wen=0, then enter CAP.
REQ-023 CAP SHALL capture mem_rdata into an internal buffer at the end of the cycle, hold mem_wen=0, then enter WR.
REQ-024 WR SHALL drive mem_addr=dst+index, mem_wdata=buffer and mem_wen=1, then increment index and words_done.
REQ-025 After WR, the block SHALL enter FIN if index+1=len or if abort has been seen, and SHALL enter RD otherwise.
REQ-026 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 Each word SHALL take exactly 3 cycles, so busy is high for 3*len+1 cycles, including the FIN cycle.
REQ-028 Address addition SHALL wrap modulo 2^ISIZE; carries SHALL be discarded.
REQ-029 Words SHALL be copied in ascending index order regardless of any src/dst overlap.
REQ-030 An abort seen in RD, CAP or WR SHALL be latched, and the in-flight word SHALL still be written.
REQ-031 Abort SHALL be ignored in IDLE and FIN. The latched abort SHALL clear on leaving FIN.
REQ-032 start SHALL be ignored whenever busy=1.
REQ-033 A start asserted in the FIN cycle SHALL be lost.
REQ-034 In IDLE, RD, CAP and FIN, mem_wen SHALL be 0. In IDLE, mem_addr SHALL be 0.
REQ-035 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-036 words_done SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-037 While rst=1, the block SHALL immediately force state=IDLE, busy=0, done=0, aborted=0, words_done=0, mem_addr=0, mem_wen=0, mem_wdata=0, and clear the buffer, index and abort latch.
REQ-038 A reset asserted mid-copy SHALL abandon the copy without completing the current write.
REQ-039 After reset, mem_wen SHALL remain 0 until a new start is accepted.

Verification
REQ-040 Memory words 0x10..0x12 hold 0xA,0xB,0xC; start with src=0x10, dst=0x40, len=3 -> words 0x40..0x42 read 0xA,0xB,0xC; busy is high for 10 cycles; one done pulse with aborted=0; words_done=3.
REQ-041 start with len=0 -> one cycle later done=1 for 1 cycle, busy is high for 1 cycle, mem_wen is never 1, words_done=0.
REQ-042 src=0xFFFF, dst=0x0005, len=2 -> words 0xFFFF and 0x0000 are copied to 0x0005 and 0x0006, confirming address wrap.
REQ-043 len=5 with abort pulsed during the 2nd word's CAP cycle -> exactly 2 words are written, then done=1 with aborted=1 and words_done=2.
REQ-044 rst asserted asynchronously during the 2nd RD of a len=4 copy -> outputs are 0 immediately and the 2nd destination word is unchanged; a new start with len=1 then completes normally.
REQ-045 start held high for an entire len=2 copy -> exactly one copy is performed and it ignores the start; the start re-sampled in IDLE after FIN begins a second copy.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word memory copier over a single synchronous-read memory port.
// Each word takes three cycles (read address, capture data, write), followed by one done cycle.
module mem_copy_engine #(
    parameter int ISIZE = 16,
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ISIZE-1:0] src,
    input  logic [ISIZE-1:0] dst,
    input  logic [ISIZE-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [ISIZE-1:0] words_done,
    output logic [ISIZE-1:0] mem_addr,
    output logic             mem_wen,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]       state, state_n;
    logic [ISIZE-1:0] src_q, dst_q, len_q, idx, wd_q;
    logic [DSIZE-1:0] data_q;
    logic             abort_q;
    logic             last;

    assign last = (idx + 1'b1) == len_q;

    always_comb begin
        state_n = state == IDLE ? (start ? (len == '0 ? FIN : RD) : IDLE) :
                  state == RD   ? CAP :
                  state == CAP  ? WR  :
                  state == WR   ? ((last || abort_q || abort) ? FIN : RD) :
                  IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                src_q <= src;
                dst_q <= dst;
                len_q <= len;
                idx   <= '0;
                wd_q  <= '0;
            end
            if (state == RD || state == CAP || state == WR)
                abort_q <= abort_q | abort;
            if (state == CAP)
                data_q <= mem_rdata;
            if (state == WR) begin
                idx  <= idx + 1'b1;
                wd_q <= wd_q + 1'b1;
            end
            if (state == FIN)
                abort_q <= 1'b0;
        end
    end

    // Outputs are pure decodes of registered state so no input reaches an output combinationally.
    assign busy       = state != IDLE;
    assign done       = state == FIN;
    assign aborted    = (state == FIN) && abort_q;
    assign words_done = wd_q;
    assign mem_wen    = state == WR;
    assign mem_addr   = state == RD ? src_q + idx : state == WR ? dst_q + idx : '0;
    assign mem_wdata  = state == WR ? data_q : '0;
endmodule
